// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: program counter and fetch control.
// Branch/jump redirect, stall, imem back-pressure.
module pc_fetch_ctrl #(
  parameter int              WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             PCsrc,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             stall,
  input  logic             imem_ready,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             fetch_valid,
  output logic             flush,
  output logic             align_err,
  output logic [15:0]      redirect_count
);

  typedef enum logic [1:0] {
    BOOT,
    FETCH,
    WAIT,
    REDIRECT
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] pc_nx;
  logic [WIDTH-1:0] tgt;
  logic             redir;
  logic             flush_nx;
  logic             align_nx;

  assign redir    = PCsrc | jump;
  assign tgt      = PCsrc ? branch_target
                          : jump_target;
  assign pc_plus4 = pc + WIDTH'(4);

  // A fetch happens only in a live state with no redirect pending
  always_comb begin
    fetch_valid = 1'b0;
    if (!redir && imem_ready && !stall &&
        (state == FETCH || state == WAIT))
      fetch_valid = 1'b1;
  end

  // Next state, next pc and redirect side effects
  always_comb begin
    state_nx = state;
    pc_nx    = pc;
    flush_nx = 1'b0;
    align_nx = 1'b0;
    if (redir) begin
      state_nx = REDIRECT;
      pc_nx    = {tgt[WIDTH-1:2], 2'b00};
      flush_nx = 1'b1;
      align_nx = |tgt[1:0];
    end else begin
      unique case (state)
        BOOT, REDIRECT: state_nx = FETCH;
        FETCH, WAIT: begin
          if (fetch_valid) begin
            pc_nx    = pc_plus4;
            state_nx = FETCH;
          end else if (!stall && !imem_ready) begin
            state_nx = WAIT;
          end
        end
        default: state_nx = BOOT;
      endcase
    end
  end

  // State, pc and one-cycle redirect strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= RESET_PC;
      flush     <= 1'b0;
      align_err <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      flush     <= flush_nx;
      align_err <= align_nx;
    end
  end

  // Saturating count of accepted redirects
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      redirect_count <= '0;
    else if (redir && redirect_count != 16'hFFFF)
      redirect_count <= redirect_count + 16'd1;
  end

endmodule
